ref_tone_gen: RTL and testbench
===============================

REF_TONE_GEN -- requirements
Module: ref_tone_gen

Interface
REQ-001 clk  in  1  system clock; all logic rising-edge.
REQ-002 reset  in  1  reset, synchronous, active-high.
REQ-003 start  in  1  one-cycle request to play the reference tone for note.
REQ-004 stop  in  1  one-cycle request to begin release early.
REQ-005 note  in  6  note number: 22 (220 Hz), 25 (261.63 Hz), 29 (329.63 Hz), 32 (392 Hz).
REQ-006 sample_req  in  1  codec output FIFO can accept a sample this cycle.
REQ-007 sample_out  out  32  signed audio sample, 24-bit magnitude in bits [23:0], sign-extended.
REQ-008 sample_wr  out  1  sample_out valid; codec writes it this cycle.
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 note_err  out  1  one-cycle pulse: start with an unsupported note.
REQ-011 done  out  1  one-cycle pulse on return to IDLE after RELEASE.

Function
REQ-012 The block SHALL implement states IDLE, ATTACK, HOLD, RELEASE.
REQ-013 The block SHALL latch note on an accepted start; note changes while busy SHALL be ignored.
REQ-014 Tuning word (24-bit) SHALL be 76896 / 91447 / 115215 / 137014 for notes 22 / 25 / 29 / 32.
REQ-015 IDLE + start + valid note SHALL go to ATTACK with env=0, phase=0, hold_cnt=0.
REQ-016 IDLE + start + invalid note SHALL stay IDLE and pulse note_err the next cycle.
REQ-017 start while busy SHALL be ignored; stop in IDLE SHALL be ignored; start and stop in the same IDLE cycle: start wins.
REQ-018 A sample SHALL be emitted only on cycles where sample_req=1 and state is not IDLE; sample_wr SHALL assert exactly one cycle later (latency 1), one write per accepted request.
REQ-019 Per emitted sample: phase += tuning word (modulo 2^24); state-specific env/counter update as REQ-021..023.
REQ-020 Sample value (square wave): +{env,8'b0} when phase[23]=0, -{env,8'b0} when phase[23]=1, computed from pre-update phase/env, two's complement, sign-extended to 32 bits.
REQ-021 ATTACK: env += ENV_STEP (0x0040) per sample; when env reaches ENV_MAX (0x4000) it SHALL saturate and go to HOLD (256 samples).
REQ-022 HOLD: hold_cnt increments per sample; after HOLD_SAMPLES (48000) samples go to RELEASE.
REQ-023 RELEASE: env -= ENV_STEP per sample, floored at 0; at env=0 go to IDLE, clear phase, pulse done.
REQ-024 stop in ATTACK or HOLD SHALL go to RELEASE next cycle from the current env; stop in RELEASE has no effect.
REQ-025 sample_req held low SHALL freeze phase, env, hold_cnt and state (except stop/reset transitions).
REQ-026 sample_out SHALL hold its last value when sample_wr=0.

Reset
REQ-027 reset SHALL force IDLE, env=0, phase=0, hold_cnt=0, latched note=0.
REQ-028 Reset values: sample_out=0, sample_wr=0, busy=0, note_err=0, done=0.
REQ-029 reset mid-tone SHALL abort immediately with no done pulse and no further sample_wr.

Structure
REQ-030 Note numbers (22/25/29/32), tuning words, ENV_STEP, ENV_MAX, HOLD_SAMPLES and the state enum SHALL live in the shared tuner package used by the tone checker.
REQ-031 The phase accumulator with note-to-tuning-word lookup SHALL be one sub-module, tone_phase_acc; FSM, envelope and output register stay in ref_tone_gen.

Verification
REQ-032 start, note=22, sample_req=1 always -> busy next cycle; 256 ramp samples then 48000 hold samples then 256 release samples (48512 sample_wr total); done pulse; phase[23] period ~218.2 samples.
REQ-033 start, note=23 -> state stays IDLE, note_err pulses once, no sample_wr.
REQ-034 note=32, sample_req toggling 1/0 -> sample_wr exactly one cycle after each high sample_req; sample sequence identical to continuous case.
REQ-035 note=25, stop after 100 samples in ATTACK (env=0x1900) -> RELEASE; exactly 100 further samples to env=0; done pulse.
REQ-036 note=29, reset asserted in HOLD -> next cycle all outputs 0, busy=0, no done; start after reset replays from env=0, phase=0.
REQ-037 start during HOLD with note=22 while playing note=32 -> ignored; tuning word stays 137014.

Source files
------------

// File: rtl/ref_tone_pkg.sv
// Shared tuner package: note numbers, tuning words, envelope constants,
// tone FSM states and note decode helpers (also used by the tone checker).
package ref_tone_pkg;

  localparam logic [5:0] NOTE_A3 = 6'd22;
  localparam logic [5:0] NOTE_C4 = 6'd25;
  localparam logic [5:0] NOTE_E4 = 6'd29;
  localparam logic [5:0] NOTE_G4 = 6'd32;

  localparam logic [23:0] TW_A3 = 24'd76896;
  localparam logic [23:0] TW_C4 = 24'd91447;
  localparam logic [23:0] TW_E4 = 24'd115215;
  localparam logic [23:0] TW_G4 = 24'd137014;

  localparam logic [15:0] ENV_STEP     = 16'h0040;
  localparam logic [15:0] ENV_MAX      = 16'h4000;
  localparam logic [15:0] HOLD_SAMPLES = 16'd48000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_HOLD,
    ST_RELEASE
  } tone_state_e;

  function automatic logic note_ok(input logic [5:0] n);
    return (n == NOTE_A3) || (n == NOTE_C4) ||
           (n == NOTE_E4) || (n == NOTE_G4);
  endfunction

  // Unsupported notes map to 0 so the phase never moves.
  function automatic logic [23:0] tuning_word(input logic [5:0] n);
    logic [23:0] tw;
    tw = '0;
    unique case (1'b1)
      (n == NOTE_A3): tw = TW_A3;
      (n == NOTE_C4): tw = TW_C4;
      (n == NOTE_E4): tw = TW_E4;
      (n == NOTE_G4): tw = TW_G4;
      default:        tw = '0;
    endcase
    return tw;
  endfunction

endpackage

// File: rtl/ref_tone_if.sv
// Control / sample interface of the reference tone generator.
// master: requester + codec side; slave: ref_tone_gen.
interface ref_tone_if;

  logic        start;
  logic        stop;
  logic [5:0]  note;
  logic        sample_req;
  logic [31:0] sample_out;
  logic        sample_wr;
  logic        busy;
  logic        note_err;
  logic        done;

  modport master (
    output start, stop, note, sample_req,
    input  sample_out, sample_wr, busy, note_err, done
  );

  modport slave (
    input  start, stop, note, sample_req,
    output sample_out, sample_wr, busy, note_err, done
  );

endinterface

// File: rtl/tone_phase_acc.sv
// Phase accumulator: latches the note on load, advances by its tuning word.
// Ports: load_i (latch note, zero phase), clr_i, adv_i, note_i, phase_o.
module tone_phase_acc
  import ref_tone_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic        adv_i,
  input  logic [5:0]  note_i,
  output logic [23:0] phase_o
);

  logic [5:0]  note_q;
  logic [23:0] phase_q;
  logic [23:0] phase_d;

  always_comb begin
    phase_d = phase_q;
    if (load_i || clr_i)
      phase_d = '0;
    else if (adv_i)
      phase_d = phase_q + tuning_word(note_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_q  <= '0;
      phase_q <= '0;
    end else begin
      if (load_i)
        note_q <= note_i;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/ref_tone_gen.sv
// Reference tone generator: square wave with attack/hold/release envelope.
// Ports: clk, reset (sync, active-high), tone (ref_tone_if.slave).
module ref_tone_gen
  import ref_tone_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  ref_tone_if.slave  tone
);

  tone_state_e state_q;
  logic [15:0] env_q;
  logic [15:0] hold_q;
  logic [31:0] out_q;
  logic        wr_q;
  logic        busy_q;
  logic        err_q;
  logic        done_q;

  logic [23:0] phase;
  logic        samp;
  logic        start_ok;
  logic        rel_end;
  logic [15:0] env_up;
  logic [15:0] env_dn;
  logic [31:0] mag;
  logic [31:0] smp;

  assign samp     = tone.sample_req && (state_q != ST_IDLE);
  assign start_ok = (state_q == ST_IDLE) && tone.start &&
                    note_ok(tone.note);
  assign env_up   = env_q + ENV_STEP;
  assign env_dn   = (env_q > ENV_STEP) ? env_q - ENV_STEP : '0;
  assign rel_end  = samp && (state_q == ST_RELEASE) &&
                    (env_dn == '0);

  // Sample uses pre-update phase and envelope.
  assign mag = {8'b0, env_q, 8'b0};
  assign smp = phase[23] ? -mag : mag;

  tone_phase_acc u_acc (
    .clk     (clk),
    .reset   (reset),
    .load_i  (start_ok),
    .clr_i   (rel_end),
    .adv_i   (samp),
    .note_i  (tone.note),
    .phase_o (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      env_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wr_q   <= samp;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      if (samp)
        out_q <= smp;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_ATTACK;
            env_q   <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b1;
          end else if (tone.start) begin
            err_q <= 1'b1;
          end
        end
        ST_ATTACK: begin
          // Stop keeps the envelope where it is.
          if (tone.stop) begin
            state_q <= ST_RELEASE;
          end else if (samp) begin
            if (env_up >= ENV_MAX) begin
              env_q   <= ENV_MAX;
              state_q <= ST_HOLD;
            end else begin
              env_q <= env_up;
            end
          end
        end
        ST_HOLD: begin
          if (tone.stop) begin
            state_q <= ST_RELEASE;
          end else if (samp) begin
            hold_q <= hold_q + 16'd1;
            if (hold_q == HOLD_SAMPLES - 16'd1)
              state_q <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (samp) begin
            env_q <= env_dn;
            if (rel_end) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tone.sample_out = out_q;
  assign tone.sample_wr  = wr_q;
  assign tone.busy       = busy_q;
  assign tone.note_err   = err_q;
  assign tone.done       = done_q;

endmodule

// File: tb/tb_ref_tone_gen.sv
// Self-checking bench for ref_tone_gen: directed scenarios with a small
// envelope/phase reference model and hand-computed sample values.
module tb_ref_tone_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  ref_tone_if t ();

  ref_tone_gen dut (
    .clk   (clk),
    .reset (rst),
    .tone  (t.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 idle, 1 attack, 2 hold, 3 release
  int          m_st;
  int          m_env;
  int          m_hold;
  logic [23:0] m_ph;
  logic [23:0] m_tw;
  logic        m_done;
  logic [31:0] m_last;

  task automatic expect_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    m_st   = 0;
    m_env  = 0;
    m_hold = 0;
    m_ph   = '0;
    m_tw   = '0;
    m_done = 1'b0;
    m_last = '0;
  endtask

  task automatic mdl_start(input logic [23:0] tw);
    m_st   = 1;
    m_env  = 0;
    m_hold = 0;
    m_ph   = '0;
    m_tw   = tw;
  endtask

  task automatic mdl_sample(output logic [31:0] e);
    logic [31:0] mag;
    mag = 32'(m_env) << 8;
    e = m_ph[23] ? (32'd0 - mag) : mag;
    m_last = e;
    m_ph = m_ph + m_tw;
    case (m_st)
      1: begin
        m_env = m_env + 64;
        if (m_env >= 16384) begin
          m_env = 16384;
          m_st  = 2;
        end
      end
      2: begin
        m_hold = m_hold + 1;
        if (m_hold == 48000) m_st = 3;
      end
      3: begin
        m_env = (m_env <= 64) ? 0 : m_env - 64;
        if (m_env == 0) begin
          m_st   = 0;
          m_ph   = '0;
          m_done = 1'b1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic req, input logic st,
                      input logic sp);
    t.sample_req = req;
    t.start      = st;
    t.stop       = sp;
    @(posedge clk);
    #1;
    t.start = 1'b0;
    t.stop  = 1'b0;
  endtask

  task automatic run(input int ncyc, input bit tog,
                     output int nwr, output int nbad,
                     output int ndone);
    logic [31:0] e;
    logic        req;
    logic        ew;
    nwr = 0;
    nbad = 0;
    ndone = 0;
    for (int i = 0; i < ncyc; i++) begin
      req = tog ? (i % 2 == 0) : 1'b1;
      ew = req && (m_st != 0);
      m_done = 1'b0;
      e = '0;
      if (ew) mdl_sample(e);
      step(req, 1'b0, 1'b0);
      if (t.sample_wr !== ew) nbad++;
      if (ew && t.sample_out !== e) nbad++;
      if (!ew && t.sample_out !== m_last) nbad++;
      if (t.done !== m_done) nbad++;
      if (t.sample_wr === 1'b1) nwr++;
      if (t.done === 1'b1) ndone++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    mdl_reset();
  endtask

  function automatic logic [35:0] outs();
    return {t.sample_wr, t.busy, t.done, t.note_err, t.sample_out};
  endfunction

  initial begin
    logic [31:0] e;
    int nwr, nb, nd;

    t.start      = 1'b0;
    t.stop       = 1'b0;
    t.note       = 6'd0;
    t.sample_req = 1'b0;
    mdl_reset();

    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("reset_outs", 32'(outs()), 32'd0);
    expect_eq("reset_flags", 32'(outs() >> 32), 32'd0);
    rst = 1'b0;

    // stop alone in idle does nothing
    step(1'b0, 1'b0, 1'b1);
    expect_eq("idle_stop_busy", 32'(t.busy), 32'd0);

    // full note 22 play; start and stop together -> start wins
    t.note = 6'd22;
    step(1'b0, 1'b1, 1'b1);
    mdl_start(24'd76896);
    expect_eq("t32_busy", 32'(t.busy), 32'd1);
    t.note = 6'd29;
    mdl_sample(e);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t32_s0", t.sample_out, 32'h0000_0000);
    mdl_sample(e);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t32_s1", t.sample_out, 32'h0000_4000);
    run(48600, 1'b0, nwr, nb, nd);
    expect_eq("t32_total_wr", 32'(nwr + 2), 32'd48512);
    expect_eq("t32_samples", 32'(nb), 32'd0);
    expect_eq("t32_done", 32'(nd), 32'd1);
    expect_eq("t32_idle", 32'(t.busy), 32'd0);

    // unsupported note
    t.note = 6'd23;
    step(1'b0, 1'b1, 1'b0);
    expect_eq("t33_err", 32'(t.note_err), 32'd1);
    expect_eq("t33_busy", 32'(t.busy), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t33_err_pulse", 32'(t.note_err), 32'd0);
    run(10, 1'b0, nwr, nb, nd);
    expect_eq("t33_no_wr", 32'(nwr), 32'd0);

    // note 32 with sample_req toggling
    t.note = 6'd32;
    step(1'b0, 1'b1, 1'b0);
    mdl_start(24'd137014);
    run(600, 1'b1, nwr, nb, nd);
    expect_eq("t34_wr", 32'(nwr), 32'd300);
    expect_eq("t34_samples", 32'(nb), 32'd0);
    do_reset();

    // note 25, stop after 100 attack samples
    t.note = 6'd25;
    step(1'b0, 1'b1, 1'b0);
    mdl_start(24'd91447);
    run(100, 1'b0, nwr, nb, nd);
    expect_eq("t35_att", 32'(nb), 32'd0);
    expect_eq("t35_last_att", t.sample_out, 32'hFFE7_4000);
    step(1'b0, 1'b0, 1'b1);
    m_st = 3;
    expect_eq("t35_busy", 32'(t.busy), 32'd1);
    mdl_sample(e);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t35_rel0", t.sample_out, 32'hFFE7_0000);
    run(120, 1'b0, nwr, nb, nd);
    expect_eq("t35_rel_wr", 32'(nwr + 1), 32'd100);
    expect_eq("t35_rel", 32'(nb), 32'd0);
    expect_eq("t35_done", 32'(nd), 32'd1);

    // note 29, reset in hold then replay
    t.note = 6'd29;
    step(1'b0, 1'b1, 1'b0);
    mdl_start(24'd115215);
    run(266, 1'b0, nwr, nb, nd);
    expect_eq("t36_pre", 32'(nb), 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t36_outs", 32'(outs()), 32'd0);
    expect_eq("t36_flags", 32'(outs() >> 32), 32'd0);
    rst = 1'b0;
    mdl_reset();
    run(5, 1'b0, nwr, nb, nd);
    expect_eq("t36_quiet", 32'(nwr + nd + nb), 32'd0);
    step(1'b0, 1'b1, 1'b0);
    mdl_start(24'd115215);
    mdl_sample(e);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t36_s0", t.sample_out, 32'h0000_0000);
    mdl_sample(e);
    step(1'b1, 1'b0, 1'b0);
    expect_eq("t36_s1", t.sample_out, 32'h0000_4000);
    do_reset();

    // start with another note during hold is ignored
    t.note = 6'd32;
    step(1'b0, 1'b1, 1'b0);
    mdl_start(24'd137014);
    run(300, 1'b0, nwr, nb, nd);
    t.note = 6'd22;
    step(1'b0, 1'b1, 1'b0);
    expect_eq("t37_busy", 32'(t.busy), 32'd1);
    run(300, 1'b0, nwr, nb, nd);
    expect_eq("t37_samples", 32'(nb), 32'd0);
    expect_eq("t37_wr", 32'(nwr), 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
